dcache_sa: RTL and testbench
============================

Name: dcache_sa

Overview:
- Parametrised set-associative, write-back, write-allocate data cache for the 5-stage pipeline. Successor to the fixed direct-mapped data cache.
- Sits between the EX/MEM stage and a word-wide backing memory.
- Returns hit data combinationally in the MEM cycle and raises `miss` to freeze all pipeline registers while it evicts or refills a line.
- Adds configurable ways, sets and line size; dirty write-back with a ready/ack memory handshake; round-robin replacement; hit/miss performance counters.

Parameters:
- ADDR_W, 11: CPU word-address width (byte address bits [ADDR_W+1:2]).
- WAYS, 2: associativity; power of two, 1..8.
- SETS, 16: number of sets; power of two, ≥2.
- LINE_WORDS, 4: 32-bit words per line; power of two, ≥2.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- cpu_addr  in  ADDR_W  word address from EX/MEM ALU result.
- cpu_re  in  1  load request.
- cpu_we  in  1  store request; takes priority over cpu_re.
- cpu_wdata  in  32  store data.
- cpu_rdata  out  32  load data; valid when cpu_re=1 and miss=0.
- miss  out  1  stall; combinational from lookup and FSM state.
- mem_req  out  1  memory transaction valid.
- mem_we  out  1  1 = write-back word, 0 = fill read.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  write-back data.
- mem_rdata  in  32  fill data; valid with mem_ack.
- mem_ack  in  1  current word accepted or returned.
- hit_cnt  out  CNT_W  lookups resolved as hits.
- miss_cnt  out  CNT_W  lookups that started a refill.

Behaviour:
- Address split: OFF_W=log2(LINE_WORDS), IDX_W=log2(SETS), TAG_W=ADDR_W-IDX_W-OFF_W. Defaults give 2/4/5.
- Reset (rst_n=0, asynchronous): all valid and dirty bits 0; round-robin pointers 0; FSM to IDLE; word counter 0; mem_req=0, mem_we=0; counters 0; miss=0. Data array contents are not reset. Reset mid-transaction abandons it and drops mem_req immediately.
- FSM states: IDLE, WB, FILL, DONE.
- IDLE with no request: miss=0.
- IDLE with request and tag hit in some valid way:
  - miss=0; cpu_rdata = hit word in the same cycle.
  - On a store, that word is written at posedge and the line's dirty bit is set.
  - hit_cnt increments by 1.
- IDLE with request and no hit:
  - miss=1 in that cycle; miss_cnt increments by 1.
  - Victim selection: lowest-index invalid way; otherwise the set's round-robin pointer.
  - Victim dirty → WB; else → FILL.
- WB:
  - mem_req=1, mem_we=1, mem_addr={victim tag, idx, cnt}, mem_wdata=victim word[cnt].
  - Each mem_ack advances cnt. The ack for word LINE_WORDS-1 clears cnt and moves to FILL. miss=1 throughout.
- FILL:
  - mem_req=1, mem_we=0, mem_addr={req tag, idx, cnt}.
  - Each mem_ack writes mem_rdata into victim word[cnt]. The last ack moves to DONE. miss=1 throughout.
- DONE (1 cycle):
  - Write the tag; set valid=1, dirty=0; pointer = (victim+1) mod WAYS; miss=1.
  - Next state IDLE, where the held request now hits and is counted in hit_cnt. A store hit sets dirty.
- mem_ack may arrive in the first cycle of mem_req; mem_req stays high until the final ack of a phase. mem_ack is ignored in IDLE and DONE.
- Zero-wait miss latency: clean miss = 6 cycles of miss=1; dirty miss = 10 cycles.
- The CPU contract: cpu_addr, cpu_re, cpu_we and cpu_wdata are held stable while miss=1.
- Counters saturate at all-ones.
- cpu_rdata = 0 when not a read hit.

Decomposition:
- Package dcache_pkg:
  - state enum (IDLE/WB/FILL/DONE);
  - clog2-based width localparams (OFF_W, IDX_W, TAG_W);
  - a helper function composing {tag, idx, off} into a word address.
- Sub-module dcache_way: one way's tag, valid, dirty and data storage, plus hit compare. It is instantiated WAYS times through a generate loop. The top level holds the FSM, victim select, round-robin pointers and counters.

Test Plan:
- Cold read, cpu_addr=0x010, memory returns 0xA0..0xA3 with zero wait → mem_addr 0x010..0x013, miss high 6 cycles, then cpu_rdata=0xA0, miss_cnt=1, hit_cnt=1.
- Read 0x012 after that fill → miss=0 in the same cycle, cpu_rdata=0xA2, hit_cnt=2, no mem_req.
- Conflicts on set 4:
  - Store 0xDEAD to 0x011 (hit, dirty), then read 0x050 (fills way1, clean) and 0x090.
  - Expect: the 0x090 read evicts way0; WB writes 0xA0, 0xDEAD, 0xA2, 0xA3 to 0x010..0x013; FILL reads 0x090..0x093; miss high 10 cycles.
- Memory with 3-cycle ack latency on a clean miss → mem_req and mem_addr held stable between acks; miss high 1+4×3+1=14 cycles; data correct.
- rst_n pulsed low during FILL word 2 → mem_req=0 and miss=0 immediately; after reset, a read of the same address misses again; counters read 0.
- cpu_we and cpu_re both high on a hit → treated as a store: word updated, dirty set, single hit_cnt increment.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and address helpers for the set-associative data cache.
// Default geometry lives here; the cache derives its own widths from its parameters.
package dcache_pkg;

  typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_t;

  localparam int ADDR_W_D     = 11;
  localparam int SETS_D       = 16;
  localparam int LINE_WORDS_D = 4;
  localparam int OFF_W        = $clog2(LINE_WORDS_D);
  localparam int IDX_W        = $clog2(SETS_D);
  localparam int TAG_W        = ADDR_W_D - IDX_W - OFF_W;

  function automatic logic [31:0] mk_addr(input logic [31:0] tag, input logic [31:0] idx,
                                          input logic [31:0] off, input int idx_w, input int off_w);
    return (tag << (idx_w + off_w)) | (idx << off_w) | off;
  endfunction

endpackage

// File: rtl/dcache_way.sv
// One cache way: per-set tag/valid/dirty, line data, and the tag compare.
module dcache_way #(
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 4,
  parameter int TAG_W      = 5,
  parameter int IDX_W      = 4,
  parameter int OFF_W      = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] idx,
  input  logic [TAG_W-1:0] tag,
  input  logic [OFF_W-1:0] rd_off,
  input  logic [OFF_W-1:0] wb_off,
  input  logic             wr_en,
  input  logic [OFF_W-1:0] wr_off,
  input  logic [31:0]      wr_data,
  input  logic             set_dirty,
  input  logic             install,
  output logic             hit,
  output logic             valid,
  output logic             dirty,
  output logic [TAG_W-1:0] tag_q,
  output logic [31:0]      rdata,
  output logic [31:0]      wbdata
);

  logic [TAG_W-1:0] tags [SETS];
  logic [31:0]      data [SETS*LINE_WORDS];
  logic [SETS-1:0]  vld, drt;

  assign valid  = vld[idx];
  assign dirty  = drt[idx];
  assign tag_q  = tags[idx];
  assign hit    = vld[idx] && (tags[idx] == tag);
  assign rdata  = data[{idx, rd_off}];
  assign wbdata = data[{idx, wb_off}];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      drt <= '0;
    end else if (install) begin
      vld[idx] <= 1'b1;
      drt[idx] <= 1'b0;
    end else if (set_dirty) begin
      drt[idx] <= 1'b1;
    end
  end

  // Tags and data need no reset: valid gates every use.
  always_ff @(posedge clk) begin
    if (install) tags[idx] <= tag;
    if (wr_en)   data[{idx, wr_off}] <= wr_data;
  end

endmodule

// File: rtl/dcache_sa.sv
// Set-associative write-back/write-allocate data cache with a blocking miss FSM,
// round-robin replacement and saturating hit/miss counters.
module dcache_sa
  import dcache_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_D,
  parameter int WAYS       = 2,
  parameter int SETS       = SETS_D,
  parameter int LINE_WORDS = LINE_WORDS_D,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_re,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              miss,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int OFFW = $clog2(LINE_WORDS);
  localparam int IDXW = $clog2(SETS);
  localparam int TAGW = ADDR_W - IDXW - OFFW;
  localparam int WAYW = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [OFFW-1:0] off, cnt;
  logic [IDXW-1:0] idx;
  logic [TAGW-1:0] tag, vic_tag;
  state_t          state;
  logic [WAYW-1:0] victim, vsel;
  logic [SETS-1:0][WAYW-1:0] rr;

  logic [WAYS-1:0]            way_hit, way_valid, way_dirty;
  logic [WAYS-1:0][TAGW-1:0]  way_tag;
  logic [WAYS-1:0][31:0]      way_rdata, way_wbdata;
  logic [31:0]                hit_word;
  logic                       req, lookup_hit, lookup_miss, last;

  assign off = cpu_addr[OFFW-1:0];
  assign idx = cpu_addr[OFFW +: IDXW];
  assign tag = cpu_addr[ADDR_W-1 -: TAGW];
  assign req = cpu_re | cpu_we;

  assign lookup_hit  = (state == IDLE) && req && (|way_hit);
  assign lookup_miss = (state == IDLE) && req && !(|way_hit);
  assign miss        = rst_n && ((state != IDLE) || lookup_miss);
  assign last        = (cnt == OFFW'(LINE_WORDS - 1));

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic sel, st;
    assign sel = (victim == WAYW'(w));
    assign st  = lookup_hit && cpu_we && way_hit[w];
    dcache_way #(
      .SETS(SETS), .LINE_WORDS(LINE_WORDS), .TAG_W(TAGW), .IDX_W(IDXW), .OFF_W(OFFW)
    ) u_way (
      .clk       (clk),
      .rst_n     (rst_n),
      .idx       (idx),
      .tag       (tag),
      .rd_off    (off),
      .wb_off    (cnt),
      .wr_en     (st || ((state == FILL) && mem_ack && sel)),
      .wr_off    ((state == FILL) ? cnt : off),
      .wr_data   ((state == FILL) ? mem_rdata : cpu_wdata),
      .set_dirty (st),
      .install   ((state == DONE) && sel),
      .hit       (way_hit[w]),
      .valid     (way_valid[w]),
      .dirty     (way_dirty[w]),
      .tag_q     (way_tag[w]),
      .rdata     (way_rdata[w]),
      .wbdata    (way_wbdata[w])
    );
  end

  always_comb begin
    hit_word = '0;
    for (int w = 0; w < WAYS; w++)
      if (way_hit[w]) hit_word = hit_word | way_rdata[w];
  end
  assign cpu_rdata = (lookup_hit && cpu_re) ? hit_word : '0;

  // Lowest-index invalid way wins; otherwise the set's round-robin pointer.
  always_comb begin
    vsel = rr[idx];
    for (int w = WAYS - 1; w >= 0; w--)
      if (!way_valid[w]) vsel = WAYW'(w);
  end

  assign vic_tag   = way_tag[victim];
  assign mem_wdata = way_wbdata[victim];
  assign mem_addr  = ADDR_W'(mk_addr(32'((state == WB) ? vic_tag : tag), 32'(idx), 32'(cnt),
                                     IDXW, OFFW));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      victim   <= '0;
      rr       <= '0;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (lookup_miss) begin
            if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
            victim  <= vsel;
            cnt     <= '0;
            mem_req <= 1'b1;
            mem_we  <= way_dirty[vsel];
            state   <= way_dirty[vsel] ? WB : FILL;
          end else if (lookup_hit) begin
            if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
          end
        end
        WB: if (mem_ack) begin
          cnt <= last ? '0 : cnt + 1'b1;
          if (last) begin
            mem_we <= 1'b0;
            state  <= FILL;
          end
        end
        FILL: if (mem_ack) begin
          cnt <= last ? '0 : cnt + 1'b1;
          if (last) begin
            mem_req <= 1'b0;
            state   <= DONE;
          end
        end
        DONE: begin
          rr[idx] <= (victim == WAYW'(WAYS - 1)) ? '0 : victim + 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_sa.sv
// Directed and random accesses to dcache_sa, checked against an abstract cache/memory model.
module tb_dcache_sa;

  logic        clk = 0, rst_n = 0;
  logic [10:0] cpu_addr = '0;
  logic        cpu_re = 0, cpu_we = 0;
  logic [31:0] cpu_wdata = '0, cpu_rdata;
  logic        miss, mem_req, mem_we, mem_ack = 0;
  logic [10:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata = '0;
  logic [31:0] hit_cnt, miss_cnt;

  dcache_sa dut (
    .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_re(cpu_re), .cpu_we(cpu_we),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .miss(miss), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // Backing memory and the CPU-visible view of memory.
  logic [31:0] back [2048];
  logic [31:0] gold [2048];
  logic [10:0] wb_a_q[$], fill_a_q[$];
  logic [31:0] wb_d_q[$];
  int latency = 1, wcnt = 0, stable_bad = 0;
  logic [10:0] hold_a;

  // Abstract cache state: 16 sets x 2 ways of tags, plus replacement pointer.
  int m_tag [16][2];
  bit m_val [16][2], m_dty [16][2];
  int m_rr [16];
  int exp_hits = 0, exp_misses = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory responder: acks after `latency` cycles of mem_req, logs every transfer.
  always @(negedge clk) begin
    if (mem_req === 1'b1 && rst_n === 1'b1) begin
      if (wcnt == 0) hold_a = mem_addr;
      else if (mem_addr !== hold_a) stable_bad++;
      if (wcnt == latency - 1) begin
        mem_ack = 1;
        wcnt = 0;
        if (mem_we) begin
          back[mem_addr] = mem_wdata;
          wb_a_q.push_back(mem_addr);
          wb_d_q.push_back(mem_wdata);
        end else begin
          mem_rdata = back[mem_addr];
          fill_a_q.push_back(mem_addr);
        end
      end else begin
        mem_ack = 0;
        wcnt++;
      end
    end else begin
      mem_ack = 0;
      wcnt = 0;
    end
  end

  task automatic access(input logic [10:0] a, input bit re, input bit we, input logic [31:0] wd,
                        input int lat, output int ncyc, output logic [31:0] rd);
    @(negedge clk); #1;
    latency = lat;
    wb_a_q.delete(); wb_d_q.delete(); fill_a_q.delete();
    cpu_addr = a; cpu_re = re; cpu_we = we; cpu_wdata = wd;
    #1;
    ncyc = 0;
    while (miss === 1'b1 && ncyc < 100) begin
      @(negedge clk); #2;
      ncyc++;
    end
    rd = cpu_rdata;
    @(posedge clk); #1;
    cpu_re = 0; cpu_we = 0;
  endtask

  task automatic model_reset();
    for (int s = 0; s < 16; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < 2; w++) begin m_val[s][w] = 0; m_dty[s][w] = 0; end
    end
    for (int i = 0; i < 2048; i++) gold[i] = back[i];
    exp_hits = 0; exp_misses = 0;
  endtask

  task automatic run(input logic [10:0] a, input bit re, input bit we, input logic [31:0] wd,
                     input int lat, output int ncyc, output logic [31:0] rd);
    int idx, tg, hw, v, exp_cyc;
    bit wb;
    logic [10:0] ewb_a[$];
    logic [31:0] ewb_d[$], exp_rd;
    idx = int'(a[5:2]); tg = int'(a[10:6]); hw = -1; wb = 0; exp_cyc = 0;
    for (int w = 0; w < 2; w++) if (m_val[idx][w] && m_tag[idx][w] == tg) hw = w;
    if (hw < 0) begin
      v = m_rr[idx];
      for (int w = 1; w >= 0; w--) if (!m_val[idx][w]) v = w;
      wb = m_val[idx][v] && m_dty[idx][v];
      if (wb)
        for (int i = 0; i < 4; i++) begin
          ewb_a.push_back(11'(m_tag[idx][v] * 64 + idx * 4 + i));
          ewb_d.push_back(gold[m_tag[idx][v] * 64 + idx * 4 + i]);
        end
      exp_cyc = 2 + 4 * lat + (wb ? 4 * lat : 0);
      m_tag[idx][v] = tg; m_val[idx][v] = 1; m_dty[idx][v] = 0;
      m_rr[idx] = (v + 1) % 2;
      hw = v;
      exp_misses++;
    end
    exp_hits++;
    exp_rd = gold[a];
    if (we) begin gold[a] = wd; m_dty[idx][hw] = 1; end

    access(a, re, we, wd, lat, ncyc, rd);

    chk("no_timeout", 32'(ncyc < 100), 32'd1);
    chk("miss_cycles", 32'(ncyc), 32'(exp_cyc));
    if (re && !we) chk("rdata", rd, exp_rd);
    chk("hit_cnt", hit_cnt, 32'(exp_hits));
    chk("miss_cnt", miss_cnt, 32'(exp_misses));
    chk("wb_count", 32'(wb_a_q.size()), 32'(ewb_a.size()));
    if (wb_a_q.size() == ewb_a.size())
      for (int i = 0; i < ewb_a.size(); i++) begin
        chk("wb_addr", 32'(wb_a_q[i]), 32'(ewb_a[i]));
        chk("wb_data", wb_d_q[i], ewb_d[i]);
      end
    chk("fill_count", 32'(fill_a_q.size()), (exp_cyc != 0) ? 32'd4 : 32'd0);
    if (exp_cyc != 0 && fill_a_q.size() == 4)
      for (int i = 0; i < 4; i++)
        chk("fill_addr", 32'(fill_a_q[i]), 32'({a[10:2], 2'b00}) + 32'(i));
  endtask

  initial begin
    int n, k, op;
    logic [31:0] rd;
    logic [10:0] a;
    for (int i = 0; i < 2048; i++) back[i] = $urandom;
    for (int i = 0; i < 4; i++) back[16 + i] = 32'hA0 + 32'(i);
    model_reset();

    // Reset state, including a request presented while reset is held.
    #3;
    chk("rst_miss", 32'(miss), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_hit_cnt", hit_cnt, 32'd0);
    chk("rst_miss_cnt", miss_cnt, 32'd0);
    cpu_re = 1; #1;
    chk("rst_miss_req", 32'(miss), 32'd0);
    cpu_re = 0;
    @(negedge clk); rst_n = 1;

    // Cold read, then a hit in the freshly filled line.
    run(11'h010, 1, 0, 0, 1, n, rd);
    chk("cold_rdata", rd, 32'hA0);
    chk("cold_cycles", 32'(n), 32'd6);
    run(11'h012, 1, 0, 0, 1, n, rd);
    chk("hit_rdata", rd, 32'hA2);
    chk("hit_no_mem", 32'(fill_a_q.size() + wb_a_q.size()), 32'd0);

    // Conflicts on set 4: dirty way0 is evicted by the third tag.
    run(11'h011, 0, 1, 32'hDEAD, 1, n, rd);
    run(11'h050, 1, 0, 0, 1, n, rd);
    run(11'h090, 1, 0, 0, 1, n, rd);
    chk("dirty_cycles", 32'(n), 32'd10);
    if (wb_d_q.size() == 4) chk("wb_dead", wb_d_q[1], 32'hDEAD);

    // Store and load together on a hit behaves as a store.
    run(11'h092, 1, 1, 32'h5555, 1, n, rd);
    run(11'h092, 1, 0, 0, 1, n, rd);
    chk("rw_store", rd, 32'h5555);

    // Slow memory: 3-cycle ack latency on a clean miss.
    run(11'h100, 1, 0, 0, 3, n, rd);
    chk("slow_cycles", 32'(n), 32'd14);
    chk("slow_stable", 32'(stable_bad), 32'd0);

    // Reset in the middle of the fill (word 2).
    @(negedge clk); #1;
    latency = 3;
    wb_a_q.delete(); wb_d_q.delete(); fill_a_q.delete();
    cpu_addr = 11'h200; cpu_re = 1;
    k = 0;
    while (fill_a_q.size() < 2 && k < 200) begin @(posedge clk); k++; end
    chk("fill_progress", 32'(k < 200), 32'd1);
    #3 rst_n = 0;
    #1;
    chk("midrst_mem_req", 32'(mem_req), 32'd0);
    chk("midrst_miss", 32'(miss), 32'd0);
    cpu_re = 0;
    @(negedge clk);
    chk("midrst_hit_cnt", hit_cnt, 32'd0);
    chk("midrst_miss_cnt", miss_cnt, 32'd0);
    rst_n = 1;
    model_reset();
    run(11'h200, 1, 0, 0, 1, n, rd);
    chk("post_rst_cycles", 32'(n), 32'd6);

    // Random traffic over a few conflicting sets.
    for (int t = 0; t < 150; t++) begin
      a = {3'b000, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      op = $urandom_range(0, 2);
      run(a, op != 1, op != 0, $urandom, $urandom_range(1, 3), n, rd);
    end
    chk("rand_stable", 32'(stable_bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
